progmem_loader: RTL and testbench



---
 rtl/progmem_loader.sv | 195 +++++++++++++++++++
 tb/tb_progmem_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/progmem_loader.sv
// Boot-time program memory loader: a count header, then little-endian 32-bit words from a byte stream.
// Define PROGMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module progmem_loader #(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_start,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [31:0]      byte_address,
  output logic             write_enable,
  output logic [31:0]      write_data,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_error,
  output logic [CNT_W-1:0] words_written
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdrLo = 3'd1;
  localparam logic [2:0] StHdrHi = 3'd2;
  localparam logic [2:0] StLoad  = 3'd3;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] StChk   = 3'd4;
`endif
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StError = 3'd6;

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [2:0]       state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      buf_q, buf_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] words_q, words_d;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  logic        active;
  logic        tmo_expire;
  logic [15:0] hdr_n;

  always_comb begin
    active = (state_q == StHdrLo) || (state_q == StHdrHi) || (state_q == StLoad);
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    active = active || (state_q == StChk);
`endif
  end

  assign hdr_n = {rx_data, count_q[7:0]};

  // rx_valid wins over an expiry landing in the same cycle.
  assign tmo_expire = active && !rx_valid && (TIMEOUT_CYCLES != 0) &&
                      ((32'(tmo_q) + 32'd1) == TIMEOUT_CYCLES);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    tmo_d      = tmo_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    words_d    = words_q;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    if (active) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (TIMEOUT_CYCLES != 0) begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end

    case (state_q)
      StIdle, StDone, StError: begin
        if (load_start) begin
          state_d    = StHdrLo;
          words_d    = '0;
          byte_idx_d = '0;
          tmo_d      = '0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      StHdrLo: begin
        if (rx_valid) begin
          count_d[7:0] = rx_data;
          state_d      = StHdrHi;
        end
      end
      StHdrHi: begin
        if (rx_valid) begin
          count_d[15:8] = rx_data;
          if (hdr_n == 16'd0 || 32'(hdr_n) > DEPTH) begin
            state_d = StError;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
`ifndef PROGMEM_LOADER_CHECKSUM_EN
        // Last word's strobe is being driven this cycle; finish right after it.
        if (32'(words_q) == 32'(count_q)) begin
          state_d = StDone;
        end else
`endif
        if (rx_valid) begin
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = 32'(words_q) << 2;
            data_d     = {rx_data, buf_q};
            words_d    = words_q + CNT_W'(1);
            byte_idx_d = 2'd0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
            if ((32'(words_q) + 32'd1) == 32'(count_q)) begin
              state_d = StChk;
            end
`endif
          end else begin
            buf_d[8*byte_idx_q +: 8] = rx_data;
            byte_idx_d               = byte_idx_q + 2'd1;
          end
        end
      end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (rx_valid) begin
          state_d = (rx_data == sum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (tmo_expire) begin
      state_d = StError;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      words_q    <= '0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      words_q    <= words_d;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign byte_address  = addr_q;
  assign write_enable  = we_q;
  assign write_data    = data_q;
  assign cpu_hold      = active;
  assign load_done     = (state_q == StDone);
  assign load_error    = (state_q == StError);
  assign words_written = words_q;

endmodule

// File: tb/tb_progmem_loader.sv
// Bench for progmem_loader: random and directed loads checked against a byte-stream model.
module tb_progmem_loader;

  localparam int unsigned Depth = 256;
  localparam int unsigned Tmo   = 16;
  localparam int unsigned CntW  = 9;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            load_start;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic [31:0]     byte_address;
  logic            write_enable;
  logic [31:0]     write_data;
  logic            cpu_hold;
  logic            load_done;
  logic            load_error;
  logic [CntW-1:0] words_written;

  int errors = 0;
  int checks = 0;

  logic [7:0]  prog[$];
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_words;
  bit          exp_ok;

  progmem_loader #(
    .DEPTH         (Depth),
    .TIMEOUT_CYCLES(Tmo),
    .CNT_W         (CntW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_start   (load_start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .byte_address (byte_address),
    .write_enable (write_enable),
    .write_data   (write_data),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      mon_addr.push_back(byte_address);
      mon_data.push_back(write_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

`ifdef PROGMEM_LOADER_CHECKSUM_EN
  task automatic append_checksum();
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 2; i < prog.size(); i++) sum += prog[i];
    prog.push_back(sum);
  endtask
`endif

  task automatic make_prog(input int n);
    int unsigned hdr;
    hdr = n;
    prog.delete();
    prog.push_back(hdr[7:0]);
    prog.push_back(hdr[15:8]);
    for (int i = 0; i < 4 * n; i++) prog.push_back(8'($urandom));
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    append_checksum();
`endif
  endtask

  // Expected writes and outcome derived straight from the byte stream in prog.
  task automatic build_model();
    int n;
    int avail;
    logic [7:0] sum;
    exp_addr.delete();
    exp_data.delete();
    exp_words = 0;
    exp_ok    = 1'b0;
    n = int'(prog[0]) + 256 * int'(prog[1]);
    if (n == 0 || n > int'(Depth)) return;
    avail = (prog.size() - 2) / 4;
    if (avail > n) avail = n;
    for (int i = 0; i < avail; i++) begin
      exp_addr.push_back(32'(4 * i));
      exp_data.push_back({prog[5 + 4 * i], prog[4 + 4 * i], prog[3 + 4 * i], prog[2 + 4 * i]});
    end
    exp_words = avail;
    if (avail < n) return;
    sum = 8'h00;
    for (int i = 0; i < 4 * n; i++) sum += prog[2 + i];
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    exp_ok = (prog.size() > 2 + 4 * n) && (prog[2 + 4 * n] == sum);
`else
    exp_ok = 1'b1;
`endif
  endtask

  task automatic run_and_check(input string name, input int gap_max, input int poke_idx);
    int waited;
    int nchk;
    build_model();
    mon_addr.delete();
    mon_data.delete();
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 || words_written !== '0)
      begin
      errors++;
      $display("FAIL %s start: hold=%b done=%b err=%b words=%0d, want 1 0 0 0", name, cpu_hold,
               load_done, load_error, words_written);
    end
    for (int i = 0; i < prog.size(); i++) begin
      if (i == poke_idx) pulse_start();
      repeat ($urandom_range(gap_max, 0)) tick();
      send_byte(prog[i]);
    end
    waited = 0;
    while (cpu_hold === 1'b1 && waited < int'(Tmo) + 8) begin
      tick();
      waited++;
    end
    checks++;
    if (cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s hold_release: cpu_hold=%b, want 0", name, cpu_hold);
    end
    checks++;
    if (load_done !== exp_ok || load_error !== !exp_ok) begin
      errors++;
      $display("FAIL %s outcome: done=%b err=%b, want done=%b err=%b", name, load_done, load_error,
               exp_ok, !exp_ok);
    end
    checks++;
    if (words_written !== CntW'(exp_words)) begin
      errors++;
      $display("FAIL %s words_written: got %0d, want %0d", name, words_written, exp_words);
    end
    checks++;
    if (mon_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d, want %0d", name, mon_addr.size(), exp_addr.size());
    end
    nchk = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
    for (int i = 0; i < nchk; i++) begin
      checks++;
      if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got addr %h data %h, want addr %h data %h", name, i,
                 mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (byte_address !== '0 || write_enable !== 1'b0 || write_data !== '0 || cpu_hold !== 1'b0 ||
        load_done !== 1'b0 || load_error !== 1'b0 || words_written !== '0) begin
      errors++;
      $display("FAIL %s: addr=%h we=%b data=%h hold=%b done=%b err=%b words=%0d, want all 0", name,
               byte_address, write_enable, write_data, cpu_hold, load_done, load_error,
               words_written);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    repeat (3) tick();
    check_all_zero("reset_state");
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    append_checksum();
`endif
    run_and_check("basic", 2, -1);
    checks++;
    if (mon_data.size() < 2 || mon_data[0] !== 32'h0000_0513 || mon_data[1] !== 32'h0010_0593 ||
        mon_addr[1] !== 32'h4) begin
      errors++;
      $display("FAIL basic_words: got %0d writes, want 0x0:00000513 0x4:00100593", mon_data.size());
    end
    // Bytes after completion must be ignored.
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    checks++;
    if (load_done !== 1'b1 || mon_addr.size() != 2 || words_written !== CntW'(2)) begin
      errors++;
      $display("FAIL done_ignores_rx: done=%b writes=%0d words=%0d, want 1 2 2", load_done,
               mon_addr.size(), words_written);
    end
  endtask

  task automatic test_header_errors();
    prog = '{8'h00, 8'h00};
    run_and_check("hdr_zero", 1, -1);
    prog = '{8'h01, 8'h01};
    run_and_check("hdr_too_big", 1, -1);
  endtask

  task automatic test_timeout();
    prog = '{8'h01, 8'h00, 8'hAA, 8'h55};
    mon_addr.delete();
    mon_data.delete();
    pulse_start();
    for (int i = 0; i < prog.size(); i++) send_byte(prog[i]);
    repeat (Tmo - 1) tick();
    checks++;
    if (load_error !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b hold=%b after %0d idle cycles, want 0 1", load_error,
               cpu_hold, Tmo - 1);
    end
    tick();
    checks++;
    if (load_error !== 1'b1 || cpu_hold !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_expire: err=%b hold=%b done=%b, want 1 0 0", load_error, cpu_hold,
               load_done);
    end
    checks++;
    if (mon_addr.size() != 0 || words_written !== '0) begin
      errors++;
      $display("FAIL timeout_no_write: writes=%0d words=%0d, want 0 0", mon_addr.size(),
               words_written);
    end
  endtask

  task automatic test_back_to_back();
    make_prog(256);
    run_and_check("b2b_full", 0, -1);
    checks++;
    if (mon_addr.size() != 256 || mon_addr[mon_addr.size() - 1] !== 32'h3FC) begin
      errors++;
      $display("FAIL b2b_last_addr: writes=%0d, want 256 ending at 0x3fc", mon_addr.size());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      make_prog($urandom_range(8, 1));
      run_and_check("random", 3, (k == 2) ? 3 : -1);
    end
  endtask

  task automatic test_reset_mid_load();
    make_prog(3);
    mon_addr.delete();
    mon_data.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(prog[i]);
    checks++;
    if (write_enable !== 1'b1 || byte_address !== 32'h0) begin
      errors++;
      $display("FAIL midload_first_write: we=%b addr=%h, want 1 00000000", write_enable,
               byte_address);
    end
    reset_n = 1'b0;
    tick();
    check_all_zero("midload_reset");
    reset_n = 1'b1;
    send_byte(8'h5A);
    checks++;
    if (cpu_hold !== 1'b0 || mon_addr.size() != 1) begin
      errors++;
      $display("FAIL midload_idle: hold=%b writes=%0d, want 0 1", cpu_hold, mon_addr.size());
    end
    make_prog(1);
    run_and_check("reload_after_reset", 2, -1);
  endtask

`ifdef PROGMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    prog = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h18};
    run_and_check("csum_good", 1, -1);
    prog = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h19};
    run_and_check("csum_bad", 1, -1);
    checks++;
    if (load_error !== 1'b1 || mon_addr.size() != 1 || mon_addr[0] !== 32'h0) begin
      errors++;
      $display("FAIL csum_bad_kept_write: err=%b writes=%0d, want 1 1", load_error,
               mon_addr.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_header_errors();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
